cbus_arbiter_n: RTL

//  N-input cache-bus (cbus) arbiter that merges icache, dcache, uncached and other bus masters onto the single cbus port to memory.

---
 rtl/cbus_arbiter_n_pkg.sv | 28 ++
 rtl/cbus_arbiter_n_rr_pick.sv | 37 +++
 rtl/cbus_arbiter_n.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/cbus_arbiter_n_pkg.sv
// Shared types for the cbus arbiter: bus request/response structs, arbiter FSM states
// and policy selector values.
package cbus_arbiter_n_pkg;

    typedef struct packed {
        logic        valid;
        logic        is_write;
        logic [31:0] addr;
        logic [63:0] data;
        logic [7:0]  strobe;
        logic [7:0]  len;       // beats in the burst minus one
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [63:0] data;
    } cbus_resp_t;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

endpackage

// File: rtl/cbus_arbiter_n_rr_pick.sv
// Combinational winner picker: rotate the request vector so the search starts at the
// round-robin pointer (or at 0 in fixed mode), then take the lowest set bit.
module cbus_rr_pick
    import cbus_arbiter_n_pkg::*;
#(
    parameter int NUM_INPUTS = 2,
    parameter int IDX_W      = 1
) (
    input  logic [NUM_INPUTS-1:0] valid_i,
    input  logic [IDX_W-1:0]      start_i,
    input  logic                  mode_i,
    output logic                  found_o,
    output logic [IDX_W-1:0]      idx_o
);

    logic [IDX_W-1:0]      base;
    logic [NUM_INPUTS-1:0] rot;
    logic [IDX_W:0]        sum;

    always_comb begin
        base    = (mode_i == 1'(ARB_RR)) ? start_i : '0;
        rot     = NUM_INPUTS'({valid_i, valid_i} >> base);
        found_o = |valid_i;
        sum     = '0;
        for (int k = NUM_INPUTS - 1; k >= 0; k--) begin
            if (rot[k]) begin
                sum = {1'b0, base} + (IDX_W + 1)'(k);
            end
        end
        // Undo the rotation: offsets past the top wrap back to index 0.
        if (sum >= (IDX_W + 1)'(NUM_INPUTS)) begin
            sum = sum - (IDX_W + 1)'(NUM_INPUTS);
        end
        idx_o = sum[IDX_W-1:0];
    end

endmodule

// File: rtl/cbus_arbiter_n.sv
// N-input cbus arbiter with burst locking and fixed/round-robin policy.
// Define CBUS_ARB_PERF_EN to build the per-input completed-grant counters.
module cbus_arbiter_n
    import cbus_arbiter_n_pkg::*;
#(
    parameter int NUM_INPUTS    = 2,
    parameter int PRIORITY_MODE = ARB_RR,
    parameter int IDX_W         = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  cbus_req_t        ireqs     [NUM_INPUTS],
    output cbus_resp_t       iresps    [NUM_INPUTS],
    output cbus_req_t        oreq,
    input  cbus_resp_t       oresp,
    output logic [IDX_W-1:0] grant_idx,
    output logic             busy,
    output logic [31:0]      grant_cnt [NUM_INPUTS]
);

    arb_state_t            state_q, state_d;
    logic [IDX_W-1:0]      grant_idx_q, grant_idx_d;
    logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic                  busy_q, busy_d;

    logic [NUM_INPUTS-1:0] req_vld;
    logic                  pick_found;
    logic [IDX_W-1:0]      pick_idx;
    cbus_req_t             owner_req;
    logic                  burst_done;
    logic                  burst_drop;
    logic [IDX_W-1:0]      next_ptr;

    always_comb begin
        for (int i = 0; i < NUM_INPUTS; i++) begin
            req_vld[i] = ireqs[i].valid;
        end
    end

    cbus_rr_pick #(
        .NUM_INPUTS (NUM_INPUTS),
        .IDX_W      (IDX_W)
    ) u_pick (
        .valid_i (req_vld),
        .start_i (rr_ptr_q),
        .mode_i  (PRIORITY_MODE == ARB_RR),
        .found_o (pick_found),
        .idx_o   (pick_idx)
    );

    assign owner_req  = ireqs[grant_idx_q];
    assign burst_done = (state_q == ARB_BUSY) && owner_req.valid && oresp.ready && oresp.last;
    assign burst_drop = (state_q == ARB_BUSY) && !owner_req.valid;
    assign next_ptr   = (grant_idx_q == IDX_W'(NUM_INPUTS - 1)) ? '0 : grant_idx_q + IDX_W'(1);

    // Every ownership ends in ARB_IDLE, so a new winner is only ever chosen there.
    always_comb begin
        state_d     = state_q;
        grant_idx_d = grant_idx_q;
        rr_ptr_d    = rr_ptr_q;
        busy_d      = busy_q;
        case (state_q)
            ARB_IDLE: begin
                if (pick_found) begin
                    grant_idx_d = pick_idx;
                    state_d     = ARB_BUSY;
                    busy_d      = 1'b1;
                end
            end
            ARB_BUSY: begin
                if (burst_done || burst_drop) begin
                    state_d = ARB_IDLE;
                    busy_d  = 1'b0;
                    if (PRIORITY_MODE == ARB_RR) begin
                        rr_ptr_d = next_ptr;
                    end
                end
            end
            default: begin
                state_d = ARB_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ARB_IDLE;
            grant_idx_q <= '0;
            rr_ptr_q    <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_idx_q <= grant_idx_d;
            rr_ptr_q    <= rr_ptr_d;
            busy_q      <= busy_d;
        end
    end

    assign grant_idx = grant_idx_q;
    assign busy      = busy_q;

    always_comb begin
        oreq = '0;
        if (state_q == ARB_BUSY) begin
            oreq = owner_req;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_INPUTS; i++) begin
            iresps[i] = '0;
            if ((state_q == ARB_BUSY) && (grant_idx_q == IDX_W'(i))) begin
                iresps[i] = oresp;
            end
        end
    end

`ifdef CBUS_ARB_PERF_EN
    logic [31:0] cnt_q [NUM_INPUTS];
    logic [31:0] cnt_d [NUM_INPUTS];

    always_comb begin
        for (int i = 0; i < NUM_INPUTS; i++) begin
            cnt_d[i] = cnt_q[i];
        end
        if (burst_done) begin
            cnt_d[grant_idx_q] = cnt_q[grant_idx_q] + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NUM_INPUTS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_INPUTS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_INPUTS; i++) begin
            grant_cnt[i] = cnt_q[i];
        end
    end
`else
    always_comb begin
        for (int i = 0; i < NUM_INPUTS; i++) begin
            grant_cnt[i] = '0;
        end
    end
`endif

endmodule
